// File: rtl/matmul_tile_accumulator.sv
// matmul_tile_accumulator: accumulates KTILES signed A*B tile products (plus bias) and emits D over valid/ready.
module matmul_tile_accumulator #(
  parameter int M      = 2,
  parameter int N      = 2,
  parameter int K      = 2,
  parameter int P      = 8,
  parameter int KTILES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [M-1:0][K-1:0][P-1:0]    a_i,
  input  logic [K-1:0][N-1:0][P-1:0]    b_i,
  input  logic [M-1:0][N-1:0][4*P-1:0]  bias_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [M-1:0][N-1:0][4*P-1:0]  d_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          busy_o
);
  localparam int W  = 4 * P;
  localparam int CW = (KTILES > 1) ? $clog2(KTILES) : 1;
  typedef enum logic {ACC, OUT} state_t;
  state_t                       state_q, state_d;
  logic [CW-1:0]                k_cnt_q, k_cnt_d;
  logic [M-1:0][N-1:0][W-1:0]   acc_q, acc_d;
  logic [W-1:0]                 s;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACC;
      k_cnt_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_cnt_q <= k_cnt_d;
      acc_q   <= acc_d;
    end
  end
  // The first tile of each output seeds from bias, later tiles from the running sum.
  always_comb begin
    state_d = state_q;
    k_cnt_d = k_cnt_q;
    acc_d   = acc_q;
    s       = '0;
    if (state_q == ACC && in_valid_i) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          s = (k_cnt_q == '0) ? bias_i[i][j] : acc_q[i][j];
          for (int k = 0; k < K; k++)
            s = s + W'($signed(a_i[i][k])) * W'($signed(b_i[k][j]));
          acc_d[i][j] = s;
        end
      end
      k_cnt_d = (k_cnt_q == CW'(KTILES - 1)) ? '0 : k_cnt_q + 1'b1;
      state_d = (k_cnt_q == CW'(KTILES - 1)) ? OUT : ACC;
    end else if (state_q == OUT && out_ready_i) begin
      state_d = ACC;
    end
  end
  assign in_ready_o  = (state_q == ACC);
  assign out_valid_o = (state_q == OUT);
  assign busy_o      = (k_cnt_q != '0);
  assign d_o         = acc_q;
endmodule

// File: tb/tb_matmul_tile_accumulator.sv
// tb_matmul_tile_accumulator: directed checks of the K-tile accumulator with hand-computed tiles.
module tb_matmul_tile_accumulator;
  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic [1:0][1:0][7:0]     a_i, b_i;
  logic [1:0][1:0][31:0]    bias_i;
  logic                     in_valid_i, in_ready_o, out_valid_o, out_ready_i, busy_o;
  logic [1:0][1:0][31:0]    d_o;
  int                       n_chk = 0;
  int                       n_pass = 0;

  matmul_tile_accumulator dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .a_i(a_i), .b_i(b_i), .bias_i(bias_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .d_o(d_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] t8(input int v00, input int v01, input int v10, input int v11);
    return {v11[7:0], v10[7:0], v01[7:0], v00[7:0]};
  endfunction

  function automatic logic [127:0] t32(input int v00, input int v01, input int v10, input int v11);
    return {v11[31:0], v10[31:0], v01[31:0], v00[31:0]};
  endfunction

  task automatic tile(input logic [31:0] a, input logic [31:0] b, input logic [127:0] bias);
    a_i = a; b_i = b; bias_i = bias; in_valid_i = 1'b1;
    @(negedge clk_i);
  endtask

  logic [31:0]  a1, b1;
  logic [127:0] d1;

  initial begin
    a1 = t8(1, 2, 3, 4);
    b1 = t8(5, 6, 7, 8);
    d1 = t32(48, 54, 96, 110);
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; bias_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_d", d_o, '0);
    chk("rst_ovalid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_iready", in_ready_o, 1);

    // Test 1: back-to-back tiles; second bias must be ignored
    tile(a1, b1, t32(10, 10, 10, 10));
    chk("t1_busy", busy_o, 1);
    chk("t1_ovalid_early", out_valid_o, 0);
    tile(a1, b1, t32(999, 999, 999, 999));
    in_valid_i = 1'b0;
    chk("t1_ovalid", out_valid_o, 1);
    chk("t1_iready_out", in_ready_o, 0);
    chk("t1_busy_out", busy_o, 0);
    chk("t1_d", d_o, d1);
    @(negedge clk_i);
    chk("t1_iready_back", in_ready_o, 1);
    chk("t1_ovalid_drop", out_valid_o, 0);

    // Test 2: signed operands
    tile(t8(-1, -1, -1, -1), t8(1, 1, 1, 1), '0);
    tile(t8(-1, -1, -1, -1), t8(1, 1, 1, 1), '0);
    in_valid_i = 1'b0;
    chk("t2_d", d_o, t32(-4, -4, -4, -4));
    @(negedge clk_i);

    // Test 3: two's complement wrap
    tile(a1, b1, t32(32'h7FFFFFFF, 0, 0, 0));
    tile('0, b1, '0);
    in_valid_i = 1'b0;
    chk("t3_d", d_o, t32(32'h80000012, 22, 43, 50));
    @(negedge clk_i);

    // Test 4: backpressure holds result and blocks input
    out_ready_i = 1'b0;
    tile(a1, b1, t32(10, 10, 10, 10));
    tile(a1, b1, t32(10, 10, 10, 10));
    chk("t4_ovalid", out_valid_o, 1);
    for (int c = 0; c < 5; c++) begin
      tile(t8(c + 1, 2 * c, -c, 7), t8(3, c, 9, -2), t32(c, c, c, c));
      chk("t4_hold_d", d_o, d1);
      chk("t4_hold_iready", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    tile(a1, b1, t32(10, 10, 10, 10));
    chk("t4_release_ovalid", out_valid_o, 0);
    chk("t4_release_busy", busy_o, 0);
    tile(a1, b1, t32(10, 10, 10, 10));
    chk("t4_restart_busy", busy_o, 1);
    tile(a1, b1, t32(10, 10, 10, 10));
    in_valid_i = 1'b0;
    chk("t4_restart_d", d_o, d1);
    @(negedge clk_i);

    // Test 5: asynchronous reset mid-accumulation
    tile(a1, b1, t32(10, 10, 10, 10));
    in_valid_i = 1'b0;
    chk("t5_busy_pre", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("t5_rst_d", d_o, '0);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_ovalid", out_valid_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    tile(a1, b1, t32(10, 10, 10, 10));
    tile(a1, b1, t32(10, 10, 10, 10));
    in_valid_i = 1'b0;
    chk("t5_d", d_o, d1);
    @(negedge clk_i);

    // Test 6: bubbles between tiles
    tile(a1, b1, t32(10, 10, 10, 10));
    in_valid_i = 1'b0;
    a_i = t8(9, 9, 9, 9);
    @(negedge clk_i);
    chk("t6_busy_gap1", busy_o, 1);
    @(negedge clk_i);
    chk("t6_busy_gap2", busy_o, 1);
    chk("t6_ovalid_gap", out_valid_o, 0);
    tile(a1, b1, t32(7, 7, 7, 7));
    in_valid_i = 1'b0;
    chk("t6_ovalid", out_valid_o, 1);
    chk("t6_d", d_o, d1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
